inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 119 +++++++++++
 tb/tb_inst_fetch_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch queue: one-outstanding I-cache fetcher feeding a CPU FIFO
// Redirect flushes the FIFO and retargets fetch; a response owed across a redirect is dropped.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        to_icache_req_valid,
  output logic [31:0] to_icache_req_addr,
  input  logic        from_icache_req_ready,
  input  logic        from_icache_rsp_valid,
  input  logic [31:0] from_icache_rsp_data,
  output logic        to_icache_rsp_ready,
  output logic        to_cpu_inst_valid,
  output logic [31:0] to_cpu_inst_pc,
  output logic [31:0] to_cpu_inst_data,
  input  logic        from_cpu_inst_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];

  logic req_hs, rsp_hs, push, pop;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= req_pc_q;
      mem_data_q[wr_ptr_q] <= from_icache_rsp_data;
    end
  end

  always_comb begin
    to_icache_req_valid = (state_q == S_REQ) && (count_q < DEPTH_C) && !redirect_valid && !rst;
    to_icache_req_addr  = fetch_pc_q;
    to_icache_rsp_ready = (state_q != S_REQ);
    to_cpu_inst_valid   = (count_q != '0);
    to_cpu_inst_pc      = mem_pc_q[rd_ptr_q];
    to_cpu_inst_data    = mem_data_q[rd_ptr_q];
  end

  always_comb begin
    req_hs     = to_icache_req_valid && from_icache_req_ready;
    rsp_hs     = to_icache_rsp_ready && from_icache_rsp_valid;
    push       = (state_q == S_WAIT) && rsp_hs && !redirect_valid;
    pop        = to_cpu_inst_valid && from_cpu_inst_ready && !redirect_valid;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    case (state_q)
      S_REQ:   if (req_hs) state_d = S_WAIT;
      S_WAIT:  if (rsp_hs) state_d = S_REQ;
               else if (redirect_valid) state_d = S_DROP;
      S_DROP:  if (rsp_hs) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (req_hs) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - vector table, async reset sequence and random run against a queue model
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        to_icache_req_valid;
  logic [31:0] to_icache_req_addr;
  logic        from_icache_req_ready = 1'b0;
  logic        from_icache_rsp_valid = 1'b0;
  logic [31:0] from_icache_rsp_data = 32'h0;
  logic        to_icache_rsp_ready;
  logic        to_cpu_inst_valid;
  logic [31:0] to_cpu_inst_pc;
  logic [31:0] to_cpu_inst_data;
  logic        from_cpu_inst_ready = 1'b0;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .to_icache_req_valid   (to_icache_req_valid),
    .to_icache_req_addr    (to_icache_req_addr),
    .from_icache_req_ready (from_icache_req_ready),
    .from_icache_rsp_valid (from_icache_rsp_valid),
    .from_icache_rsp_data  (from_icache_rsp_data),
    .to_icache_rsp_ready   (to_icache_rsp_ready),
    .to_cpu_inst_valid     (to_cpu_inst_valid),
    .to_cpu_inst_pc        (to_cpu_inst_pc),
    .to_cpu_inst_data      (to_cpu_inst_data),
    .from_cpu_inst_ready   (from_cpu_inst_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rs, rd;
    logic [31:0] rpc;
    logic        rr, sv;
    logic [31:0] sd;
    logic        cr;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_srdy, e_iv;
    logic [31:0] e_ipc, e_idata;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rs, logic rd, logic [31:0] rpc, logic rr, logic sv,
                              logic [31:0] sd, logic cr, logic e_rqv, logic [31:0] e_addr,
                              logic e_srdy, logic e_iv, logic [31:0] e_ipc, logic [31:0] e_idata);
    vec_t v;
    v.rs = rs; v.rd = rd; v.rpc = rpc; v.rr = rr; v.sv = sv; v.sd = sd; v.cr = cr;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_srdy = e_srdy; v.e_iv = e_iv;
    v.e_ipc = e_ipc; v.e_idata = e_idata;
    return v;
  endfunction

  function automatic logic [31:0] dw(int n);
    return 32'hC0DE_0000 | n;
  endfunction

  task automatic check_outputs(input string tag, input logic e_rqv, input logic [31:0] e_addr,
                               input logic e_srdy, input logic e_iv,
                               input logic [31:0] e_ipc, input logic [31:0] e_idata);
    chk({tag, ".req_valid"}, {31'b0, to_icache_req_valid}, {31'b0, e_rqv});
    if (e_rqv) chk({tag, ".req_addr"}, to_icache_req_addr, e_addr);
    chk({tag, ".rsp_ready"}, {31'b0, to_icache_rsp_ready}, {31'b0, e_srdy});
    chk({tag, ".inst_valid"}, {31'b0, to_cpu_inst_valid}, {31'b0, e_iv});
    if (e_iv) begin
      chk({tag, ".inst_pc"}, to_cpu_inst_pc, e_ipc);
      chk({tag, ".inst_data"}, to_cpu_inst_data, e_idata);
    end
  endtask

  logic [31:0] m_pc, m_rpc, ic_addr;
  logic        m_out, m_drop, ic_pend;
  int          ic_delay;
  ent_t        mq[$];

  initial begin
    // rs rd rpc rr sv sd cr | rqv addr srdy iv ipc idata
    vt.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,dw(0),0, 0,0,1,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h4,0,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,0,1,dw(1),0, 0,0,1,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h8,0,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,0,1,dw(2),0, 0,0,1,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'hC,0,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,0,1,dw(3),0, 0,0,1,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,1,0,0,0, 0,0,0,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,1,0,0,1, 0,0,0,1,32'h0,dw(0)));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h10,0,1,32'h4,dw(1)));
    vt.push_back(mk(0,0,0,0,0,0,0, 0,0,1,1,32'h4,dw(1)));
    vt.push_back(mk(0,0,0,0,1,dw(4),0, 0,0,1,1,32'h4,dw(1)));
    vt.push_back(mk(0,0,0,1,0,0,0, 0,0,0,1,32'h4,dw(1)));
    vt.push_back(mk(0,1,32'h50,1,0,0,0, 0,0,0,1,32'h4,dw(1)));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h50,0,0,0,0));
    vt.push_back(mk(0,1,32'h1002,1,0,0,0, 0,0,1,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0, 0,0,1,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0, 0,0,1,0,0,0));
    vt.push_back(mk(0,0,0,1,1,32'hDEAD_BEEF,0, 0,0,1,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h1000,0,0,0,0));
    vt.push_back(mk(0,1,32'h2000,0,1,32'hBAD0_0001,0, 0,0,1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0, 1,32'h2000,0,0,0,0));
    vt.push_back(mk(0,1,32'hFFFF_FFFE,1,0,0,0, 0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'hFFFF_FFFC,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,dw(5),0, 0,0,1,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h0,0,1,32'hFFFF_FFFC,dw(5)));
    vt.push_back(mk(0,0,0,0,1,dw(6),0, 0,0,1,1,32'hFFFF_FFFC,dw(5)));
    vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h4,0,1,32'hFFFF_FFFC,dw(5)));
    vt.push_back(mk(0,0,0,0,1,dw(7),1, 0,0,1,1,32'hFFFF_FFFC,dw(5)));
    vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h8,0,1,32'h0,dw(6)));
    vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h8,0,1,32'h4,dw(7)));
    vt.push_back(mk(0,0,0,0,0,0,0, 1,32'h8,0,0,0,0));

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rs; redirect_valid = vt[i].rd; redirect_pc = vt[i].rpc;
      from_icache_req_ready = vt[i].rr; from_icache_rsp_valid = vt[i].sv;
      from_icache_rsp_data = vt[i].sd; from_cpu_inst_ready = vt[i].cr;
      #1;
      check_outputs($sformatf("vec%0d", i), vt[i].e_rqv, vt[i].e_addr, vt[i].e_srdy,
                    vt[i].e_iv, vt[i].e_ipc, vt[i].e_idata);
    end

    // Reset raised mid-cycle while a response is owed and the FIFO holds one entry.
    @(negedge clk);
    redirect_valid = 0; from_icache_req_ready = 1; from_icache_rsp_valid = 0; from_cpu_inst_ready = 0;
    @(negedge clk);
    from_icache_req_ready = 0; from_icache_rsp_valid = 1; from_icache_rsp_data = dw(8);
    @(negedge clk);
    from_icache_rsp_valid = 0; from_icache_req_ready = 1;
    @(negedge clk);
    from_icache_req_ready = 0;
    #1;
    check_outputs("pre_rst", 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, dw(8));
    #1 rst = 1;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 0;
    #1;
    check_outputs("rst_release", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    m_pc = 32'h0; m_rpc = 32'h0; m_out = 0; m_drop = 0; mq.delete();
    ic_pend = 0; ic_addr = 32'h0; ic_delay = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_rqv, m_req_hs, m_rsp_hs, m_pop, d_req_hs, d_rsp_hs;
      logic [31:0] d_addr;
      @(negedge clk);
      redirect_valid = ($urandom % 20) == 0;
      case ($urandom % 4)
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF8;
        2:       redirect_pc = 32'h0000_1002;
        default: redirect_pc = 32'hFFFF_FFFF;
      endcase
      from_icache_req_ready = ($urandom % 4) != 0;
      from_cpu_inst_ready   = ($urandom % 3) != 0;
      from_icache_rsp_valid = ic_pend && (ic_delay == 0);
      from_icache_rsp_data  = ic_pend ? (ic_addr ^ 32'h5A5A_1234) : $urandom;
      #1;
      e_rqv = !m_out && (mq.size() < DEPTH) && !redirect_valid;
      if (mq.size() != 0)
        check_outputs("rand", e_rqv, m_pc, m_out, 1'b1, mq[0].pc, mq[0].data);
      else
        check_outputs("rand", e_rqv, m_pc, m_out, 1'b0, 32'h0, 32'h0);
      d_req_hs = to_icache_req_valid && from_icache_req_ready;
      d_rsp_hs = to_icache_rsp_ready && from_icache_rsp_valid;
      d_addr   = to_icache_req_addr;
      @(posedge clk);
      m_req_hs = e_rqv && from_icache_req_ready;
      m_rsp_hs = m_out && from_icache_rsp_valid;
      m_pop    = (mq.size() != 0) && from_cpu_inst_ready;
      if (redirect_valid) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_out && !m_rsp_hs) m_drop = 1;
        else begin m_out = 0; m_drop = 0; end
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_rsp_hs) begin
          if (!m_drop) mq.push_back('{pc: m_rpc, data: from_icache_rsp_data});
          m_out = 0; m_drop = 0;
        end
        if (m_req_hs) begin
          m_rpc = m_pc; m_pc = m_pc + 32'd4; m_out = 1;
        end
      end
      if (d_rsp_hs) ic_pend = 0;
      if (d_req_hs) begin
        ic_pend = 1; ic_addr = d_addr; ic_delay = $urandom % 4;
      end else if (ic_pend && ic_delay > 0) begin
        ic_delay--;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
